fir_filter_mac: RTL

Parametrised multi-channel FIR filter for the audio path. It replaces the fixed 4-coefficient filter with a time-multiplexed single-multiplier MAC engine. It has run-time loadable coefficients, a separate delay line per channel, and valid/ready handshakes on both sides. It sits between the audio sample receiver and the output serialiser, processing one signed sample per transaction.

---
 rtl/fir_filter_mac.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/fir_filter_mac.sv
// fir_filter_mac: multi-channel FIR filter built around one time-multiplexed
// multiplier. Each accepted sample is shifted into its channel's delay line.
// The engine then accumulates one tap product per cycle, rounds the sum and
// narrows it. The result is held on the output until the downstream side
// takes it.
// The optional macro FIR_FILTER_SAT_EN clamps the rounded result to the
// DATA_W range. When the macro is undefined, the result wraps.
module fir_filter_mac #(
  parameter int DATA_W     = 24,
  parameter int COEFF_W    = 18,
  parameter int COEFF_FRAC = 16,
  parameter int NUM_TAPS   = 8,
  parameter int NUM_CH     = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int TAP_W     = $clog2(NUM_TAPS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CH_W-1:0]    in_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CH_W-1:0]    out_ch,
  input  logic               coef_we,
  input  logic [TAP_W-1:0]   coef_addr,
  input  logic [COEFF_W-1:0] coef_wdata,
  output logic               busy
);

  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int ACC_W  = PROD_W + $clog2(NUM_TAPS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic signed [ACC_W-1:0]   RND_HALF = ACC_W'(64'sd1 <<< (COEFF_FRAC - 1));
  localparam logic signed [COEFF_W-1:0] H_UNITY  = COEFF_W'(64'sd1 <<< COEFF_FRAC);

  logic [1:0]                state_q, state_d;
  logic [TAP_W-1:0]          k_q, k_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  x_q [NUM_CH][NUM_TAPS];
  logic signed [DATA_W-1:0]  x_d [NUM_CH][NUM_TAPS];
  logic signed [COEFF_W-1:0] h_q [NUM_TAPS];
  logic signed [COEFF_W-1:0] h_d [NUM_TAPS];
  logic                      out_valid_q, out_valid_d;
  logic [DATA_W-1:0]         out_data_q, out_data_d;
  logic [CH_W-1:0]           out_ch_q, out_ch_d;

  logic                      in_ch_ok_s;
  logic                      addr_ok_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic [DATA_W-1:0]         narrow_s;

  // When the index width exactly covers the range, every index is legal.
  if (NUM_CH == (1 << CH_W)) begin : g_ch_full
    assign in_ch_ok_s = 1'b1;
  end else begin : g_ch_part
    assign in_ch_ok_s = (in_ch < CH_W'(NUM_CH));
  end

  if (NUM_TAPS == (1 << TAP_W)) begin : g_tap_full
    assign addr_ok_s = 1'b1;
  end else begin : g_tap_part
    assign addr_ok_s = (coef_addr < TAP_W'(NUM_TAPS));
  end

  // Full-precision product of the current tap; both operands are signed.
  assign prod_s = x_q[ch_q][k_q] * h_q[k_q];

`ifdef FIR_FILTER_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (DATA_W - 1)));
  logic signed [ACC_W-1:0] r_s;
  assign r_s = (acc_q + RND_HALF) >>> COEFF_FRAC;

  // Round half toward +inf, then clamp to the signed DATA_W range.
  always_comb begin
    if (r_s > SAT_MAX) begin
      narrow_s = SAT_MAX[DATA_W-1:0];
    end else if (r_s < SAT_MIN) begin
      narrow_s = SAT_MIN[DATA_W-1:0];
    end else begin
      narrow_s = r_s[DATA_W-1:0];
    end
  end
`else
  // Round half toward +inf, then keep the low DATA_W bits (wrap).
  always_comb begin
    narrow_s = DATA_W'((acc_q + RND_HALF) >>> COEFF_FRAC);
  end
`endif

  // Control FSM, delay-line shift, coefficient writes and MAC datapath.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ch_d        = ch_q;
    acc_d       = acc_q;
    x_d         = x_q;
    h_d         = h_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    case (state_q)
      ST_IDLE: begin
        // The coefficient is written before the new sample's accumulation starts.
        if (coef_we && addr_ok_s) begin
          h_d[coef_addr] = coef_wdata;
        end else begin
          h_d = h_q;
        end
        if (in_valid && in_ch_ok_s) begin
          for (int t = NUM_TAPS - 1; t > 0; t--) begin
            x_d[in_ch][t] = x_q[in_ch][t-1];
          end
          x_d[in_ch][0] = in_data;
          ch_d          = in_ch;
          acc_d         = {ACC_W{1'b0}};
          k_d           = {TAP_W{1'b0}};
          state_d       = ST_ACCUM;
        end else begin
          // A sample on an out-of-range channel is consumed and dropped.
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        acc_d = acc_q + ACC_W'(prod_s);
        if (k_q == TAP_W'(NUM_TAPS - 1)) begin
          state_d = ST_ROUND;
        end else begin
          k_d = k_q + {{(TAP_W-1){1'b0}}, 1'b1};
        end
      end
      ST_ROUND: begin
        out_data_d  = narrow_s;
        out_ch_d    = ch_q;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers; reset restores a pass-through filter with empty delay lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      k_q         <= {TAP_W{1'b0}};
      ch_q        <= {CH_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_ch_q    <= {CH_W{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        for (int t = 0; t < NUM_TAPS; t++) begin
          x_q[c][t] <= {DATA_W{1'b0}};
        end
      end
      for (int t = 0; t < NUM_TAPS; t++) begin
        h_q[t] <= (t == 0) ? H_UNITY : {COEFF_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ch_q        <= ch_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      x_q         <= x_d;
      h_q         <= h_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
